df_param_loader: RTL
====================

# df_param_loader

Deserializes a stream of 32-bit configuration words into one complete `df_ctrl_pkg::DMAParams` set (tile and DMA pointers) and hands it to the dataflow controller over a valid/ready handshake. It sits between the host configuration path and the df controller. It is double-buffered: a staging register assembles the next set while the output register holds the current one. A set is 19 words in a fixed word map.

## Interface
Parameters:
- `NWORDS`, 19: words per parameter set. Fixed by the word map; not meant to be overridden.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. Synchronous, active-high.
- `i_clear`  in  1  synchronous flush of the staging buffer and the output buffer.
- `i_in_data`  in  32  configuration word.
- `i_in_valid`  in  1  word valid.
- `i_in_last`  in  1  marks the final word of a set.
- `o_in_ready`  out  1  loader accepts a word.
- `o_params`  out  DMAParams struct  current parameter set.
- `o_params_valid`  out  1  `o_params` holds a complete set.
- `i_params_ready`  in  1  controller consumes the set.
- `o_err`  out  1  one-cycle pulse on a framing error.

## Operation
- A word is accepted when `i_in_valid & o_in_ready`.
- Word index `idx` (5 bits, 0..18) selects the destination fields in staging. Unlisted bits are ignored. "lo" means bits [11:0]; "hi" means bits [27:16].
  - W0: tile.x_lim lo, tile.y_lim hi.
  - W1: tile.k_lim lo, tile.c_lim hi.
  - W2: tile.psums.x_step lo, tile.ifmaps.x_step hi.
  - W3: dma.psums.k_lim lo, dma.ifmaps.y_step hi.
  - W4: dma.ifmaps.y_lim lo, dma.ifmaps.c_lim hi.
  - W5: dma.weights.w_step lo, tile.weights.c_step [31:16].
  - W6: tile.weights.k_step [19:0].
  - W7..W18 take bits [23:0], in this order: tile.psums.y_step, tile.psums.k_step, tile.ifmaps.y_step, tile.ifmaps.c_step, dma.psums.ett, dma.psums.y_step, dma.psums.y_lim, dma.psums.k_step, dma.ifmaps.ett, dma.ifmaps.c_step, dma.weights.ett, dma.weights.w_lim.
- Framing:
  - `i_in_last` on the accepted word at idx 18 completes the set.
  - `i_in_last` at idx < 18, or missing at idx 18, is a framing error. On an error: pulse `o_err`, discard the staging contents, reset idx to 0. The output buffer is unaffected.
- Staging has two states:
  - FILL: `o_in_ready`=1.
  - FULL: `o_in_ready`=0. Entered on a completed set when the output buffer is valid and not being consumed in that cycle.
- Transfer from staging to output occurs when staging completes (or is FULL) and either:
  - `o_params_valid`=0, or
  - `o_params_valid & i_params_ready` in the same cycle.
- After a transfer, staging returns to FILL with idx=0.
- `o_params_valid` clears on a handshake unless a transfer happens in the same cycle, in which case it stays 1.
- `i_clear`: idx=0, staging→FILL, `o_params_valid`=0. `o_params` keeps its value. Words presented during `i_clear` are dropped and `o_err` is not raised.

## Timing
- Reset values:
  - `o_params_valid`=0, `o_err`=0, `o_params`=all zeros.
  - `o_in_ready`=0 while `i_rst`=1, and 1 in the first cycle after release.
  - idx=0, staging in FILL.
- `o_in_ready` is a combinational function of the staging state only. It never depends on `i_in_valid`.
- Latency: the last word is accepted in cycle N. If the output buffer is free, `o_params_valid`=1 and `o_params` is updated in cycle N+1.
- Throughput: with `i_params_ready` held at 1 and words every cycle, a set completes every 19 cycles with no bubbles.
- `o_params` is stable while `o_params_valid`=1 until the handshake.
- `o_err` asserts the cycle after the offending word is accepted.
- Reset asserted mid-set: all state returns to reset values on the next edge. Partial sets are lost.

## Test plan
- Single set: feed words W_i = 0x0A000000 | i, with `i_in_last` on W18, controller ready. Required: `o_params_valid` rises exactly 1 cycle after W18; tile.x_lim=0x000, dma.weights.w_lim=0x000012, tile.weights.c_step=0x0A00.
- Field isolation: W0=0xFABCFDEF. Required: x_lim=0xDEF, y_lim=0xABC; bits [31:28] and [15:12] have no effect.
- Backpressure: hold `i_params_ready`=0 and send two full sets. Required:
  - set 1 is held on `o_params`;
  - after the second W18, `o_in_ready`=0;
  - asserting ready yields set 1, then set 2 on the next cycle, then `o_in_ready`=1.
- Framing errors: `i_in_last` on W5.
  - Required: `o_err` pulses once, idx restarts, and a following correct set loads cleanly.
  - Also run 19 words without last. Required: error on W18.
- Simultaneous consume and transfer: `i_params_ready`=1 in the same cycle the next W18 is accepted. Required: `o_params_valid` stays 1 with no gap, and `o_params` switches to set 2.
- Clear and reset mid-set: after 10 words, pulse `i_clear`. Required: `o_params_valid`=0 and the next full set loads correctly. Repeat the sequence with `i_rst`. Required: `o_params`=0 and `o_in_ready` is back to 1 one cycle after release.

Source files
------------

// File: rtl/df_param_loader_if.sv
// Parameter-set payload types and the loader's stream/handshake bundle.
// Host side uses the master modport, the loader the slave modport.
package df_ctrl_pkg;

    typedef struct packed {
        logic [11:0] x_step;
        logic [23:0] y_step;
        logic [23:0] k_step;
    } tile_psums_t;

    typedef struct packed {
        logic [11:0] x_step;
        logic [23:0] y_step;
        logic [23:0] c_step;
    } tile_ifmaps_t;

    typedef struct packed {
        logic [15:0] c_step;
        logic [19:0] k_step;
    } tile_weights_t;

    typedef struct packed {
        logic [11:0]   x_lim;
        logic [11:0]   y_lim;
        logic [11:0]   k_lim;
        logic [11:0]   c_lim;
        tile_psums_t   psums;
        tile_ifmaps_t  ifmaps;
        tile_weights_t weights;
    } tile_params_t;

    typedef struct packed {
        logic [11:0] k_lim;
        logic [23:0] ett;
        logic [23:0] y_step;
        logic [23:0] y_lim;
        logic [23:0] k_step;
    } dma_psums_t;

    typedef struct packed {
        logic [11:0] y_step;
        logic [11:0] y_lim;
        logic [11:0] c_lim;
        logic [23:0] ett;
        logic [23:0] c_step;
    } dma_ifmaps_t;

    typedef struct packed {
        logic [11:0] w_step;
        logic [23:0] ett;
        logic [23:0] w_lim;
    } dma_weights_t;

    typedef struct packed {
        dma_psums_t   psums;
        dma_ifmaps_t  ifmaps;
        dma_weights_t weights;
    } dma_params_t;

    typedef struct packed {
        tile_params_t tile;
        dma_params_t  dma;
    } DMAParams;

endpackage

interface df_param_loader_if;
    import df_ctrl_pkg::*;

    logic [31:0] i_in_data;
    logic        i_in_valid;
    logic        i_in_last;
    logic        o_in_ready;
    DMAParams    o_params;
    logic        o_params_valid;
    logic        i_params_ready;
    logic        o_err;

    modport slave (
        input  i_in_data, i_in_valid, i_in_last, i_params_ready,
        output o_in_ready, o_params, o_params_valid, o_err
    );

    modport master (
        output i_in_data, i_in_valid, i_in_last, i_params_ready,
        input  o_in_ready, o_params, o_params_valid, o_err
    );
endinterface

// File: rtl/df_param_loader.sv
// Double-buffered deserializer: assembles 19 config words into a DMAParams
// set in staging and hands it to the controller through the output register.
module df_param_loader
    import df_ctrl_pkg::*;
#(
    parameter int unsigned NWORDS = 19
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    df_param_loader_if.slave bus
);

    localparam int unsigned      IDX_W    = 5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic { FILL, FULL } stage_state_e;

    stage_state_e     state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    DMAParams         stage, stage_nxt, stage_wr;
    DMAParams         params_nxt;
    logic             valid_nxt;
    logic             err_nxt;

    logic accept, at_last, complete, frame_err, consume, xfer;

    // Merge one word into a copy of the staging set according to the word map.
    function automatic DMAParams write_word(input DMAParams p, input logic [IDX_W-1:0] i,
                                            input logic [31:0] w);
        DMAParams r;
        r = p;
        case (i)
            5'd0:  begin r.tile.x_lim = w[11:0];           r.tile.y_lim = w[27:16];          end
            5'd1:  begin r.tile.k_lim = w[11:0];           r.tile.c_lim = w[27:16];          end
            5'd2:  begin r.tile.psums.x_step = w[11:0];    r.tile.ifmaps.x_step = w[27:16];  end
            5'd3:  begin r.dma.psums.k_lim = w[11:0];      r.dma.ifmaps.y_step = w[27:16];   end
            5'd4:  begin r.dma.ifmaps.y_lim = w[11:0];     r.dma.ifmaps.c_lim = w[27:16];    end
            5'd5:  begin r.dma.weights.w_step = w[11:0];   r.tile.weights.c_step = w[31:16]; end
            5'd6:  r.tile.weights.k_step = w[19:0];
            5'd7:  r.tile.psums.y_step   = w[23:0];
            5'd8:  r.tile.psums.k_step   = w[23:0];
            5'd9:  r.tile.ifmaps.y_step  = w[23:0];
            5'd10: r.tile.ifmaps.c_step  = w[23:0];
            5'd11: r.dma.psums.ett       = w[23:0];
            5'd12: r.dma.psums.y_step    = w[23:0];
            5'd13: r.dma.psums.y_lim     = w[23:0];
            5'd14: r.dma.psums.k_step    = w[23:0];
            5'd15: r.dma.ifmaps.ett      = w[23:0];
            5'd16: r.dma.ifmaps.c_step   = w[23:0];
            5'd17: r.dma.weights.ett     = w[23:0];
            5'd18: r.dma.weights.w_lim   = w[23:0];
            default: ;
        endcase
        return r;
    endfunction

    // Ready is a decode of the staging state; words offered during clear are dropped.
    assign bus.o_in_ready = (state == FILL) & ~i_rst;

    assign accept    = bus.i_in_valid & (state == FILL) & ~i_clear;
    assign at_last   = (idx == LAST_IDX);
    assign complete  = accept & bus.i_in_last & at_last;
    assign frame_err = accept & (bus.i_in_last ^ at_last);
    assign stage_wr  = write_word(stage, idx, bus.i_in_data);
    assign consume   = bus.o_params_valid & bus.i_params_ready;
    assign xfer      = (complete | (state == FULL)) & (~bus.o_params_valid | consume);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= FILL;
            idx                <= '0;
            stage              <= '0;
            bus.o_params       <= '0;
            bus.o_params_valid <= 1'b0;
            bus.o_err          <= 1'b0;
        end else begin
            state              <= state_nxt;
            idx                <= idx_nxt;
            stage              <= stage_nxt;
            bus.o_params       <= params_nxt;
            bus.o_params_valid <= valid_nxt;
            bus.o_err          <= err_nxt;
        end
    end

    // Next state: framing, staging fill, and staging-to-output transfer.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        stage_nxt  = stage;
        params_nxt = bus.o_params;
        valid_nxt  = bus.o_params_valid;
        err_nxt    = 1'b0;

        if (i_clear) begin
            state_nxt = FILL;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            if (frame_err) begin
                idx_nxt   = '0;
                stage_nxt = '0;
                err_nxt   = 1'b1;
            end else if (accept) begin
                stage_nxt = stage_wr;
                idx_nxt   = complete ? '0 : idx + IDX_W'(1);
            end

            if (xfer) begin
                params_nxt = complete ? stage_wr : stage;
                valid_nxt  = 1'b1;
                state_nxt  = FILL;
            end else begin
                if (consume) begin
                    valid_nxt = 1'b0;
                end
                if (complete) begin
                    state_nxt = FULL;
                end
            end
        end
    end

endmodule
